// File: rtl/psr_wim_unit_pkg.sv
// Shared definitions for the PSR/WIM unit: exception codes, PSR field
// positions and the run/error state encoding.
package psr_wim_unit_pkg;

    localparam logic [2:0] EXC_NONE          = 3'd0;
    localparam logic [2:0] EXC_OVERFLOW      = 3'd1;
    localparam logic [2:0] EXC_UNDERFLOW     = 3'd2;
    localparam logic [2:0] EXC_ILLEGAL_INSTR = 3'd3;
    localparam logic [2:0] EXC_PRIVILEGED    = 3'd4;
    localparam logic [2:0] EXC_ILLEGAL_PSR   = 3'd5;

    localparam int PSR_IMPL_LSB = 28;
    localparam int PSR_VER_LSB  = 24;
    localparam int PSR_ICC_LSB  = 20;
    localparam int PSR_PIL_LSB  = 8;
    localparam int PSR_S_BIT    = 7;
    localparam int PSR_PS_BIT   = 6;
    localparam int PSR_ET_BIT   = 5;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } psr_state_e;

endpackage

// File: rtl/psr_cwp_mod.sv
// Neighbouring window pointers: (cwp-1) and (cwp+1) modulo NWINDOWS,
// correct for non-power-of-two window counts.
module psr_cwp_mod #(
    parameter int NWINDOWS = 8,
    parameter int CWPW     = 3
) (
    input  logic [CWPW-1:0] cwp,
    output logic [CWPW-1:0] cwp_dec,
    output logic [CWPW-1:0] cwp_inc
);

    localparam logic [CWPW-1:0] LAST = CWPW'(NWINDOWS - 1);

    assign cwp_dec = (cwp == '0)   ? LAST : cwp - CWPW'(1);
    assign cwp_inc = (cwp == LAST) ? '0   : cwp + CWPW'(1);

endmodule

// File: rtl/psr_wim_unit.sv
// Processor state and window invalid mask registers: window save/restore,
// trap entry/return, WRPSR/WRWIM with registered exception reporting.
module psr_wim_unit
    import psr_wim_unit_pkg::*;
#(
    parameter int         NWINDOWS = 8,
    parameter logic [3:0] IMPL     = 4'h0,
    parameter logic [3:0] VER      = 4'h0,
    localparam int        CWPW     = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     psr_in,
    input  logic            psr_wr,
    input  logic [31:0]     wim_in,
    input  logic            wim_wr,
    input  logic [3:0]      icc_in,
    input  logic            icc_wr,
    input  logic            save_req,
    input  logic            restore_req,
    input  logic            trap_req,
    input  logic            rett_req,
    output logic [31:0]     psr_out,
    output logic [31:0]     wim_out,
    output logic [CWPW-1:0] cwp_out,
    output logic [3:0]      icc_out,
    output logic            s_out,
    output logic            ps_out,
    output logic            et_out,
    output logic            exc_valid,
    output logic [2:0]      exc_code,
    output logic            error_mode
);

    localparam logic [63:0] WIM_MASK64 = (64'd1 << NWINDOWS) - 64'd1;
    localparam logic [31:0] WIM_MASK   = WIM_MASK64[31:0];

    psr_state_e      state_q, state_d;
    logic [3:0]      icc_q, icc_d, pil_q, pil_d;
    logic            s_q, s_d, ps_q, ps_d, et_q, et_d;
    logic [CWPW-1:0] cwp_q, cwp_d, cwp_dec, cwp_inc;
    logic [31:0]     wim_q, wim_d;
    logic            exc_valid_q, exc_valid_d;
    logic [2:0]      exc_code_q, exc_code_d;
    logic            icc_en, psr_bad;

    // Reserved, EC and EF bits of WRPSR data are never stored.
    logic unused_psr_bits;
    assign unused_psr_bits = ^{psr_in[31:24], psr_in[19:12]};

    psr_cwp_mod #(.NWINDOWS(NWINDOWS), .CWPW(CWPW)) u_cwp (
        .cwp     (cwp_q),
        .cwp_dec (cwp_dec),
        .cwp_inc (cwp_inc)
    );

    assign psr_bad = ({27'd0, psr_in[4:0]} >= 32'(NWINDOWS));

    always_comb begin
        state_d    = state_q;
        icc_d      = icc_q;
        pil_d      = pil_q;
        s_d        = s_q;
        ps_d       = ps_q;
        et_d       = et_q;
        cwp_d      = cwp_q;
        wim_d      = wim_q;
        exc_code_d = EXC_NONE;
        icc_en     = 1'b0;
        if (state_q == ST_RUN) begin
            icc_en = icc_wr;
            if (trap_req) begin
                icc_en = 1'b0;
                if (et_q) begin
                    ps_d  = s_q;
                    s_d   = 1'b1;
                    et_d  = 1'b0;
                    cwp_d = cwp_dec;
                end else begin
                    state_d = ST_ERROR;
                end
            end else if (rett_req) begin
                // A faulting RETT leaves every PSR field, icc included, alone.
                if (et_q) begin
                    exc_code_d = EXC_ILLEGAL_INSTR;
                    icc_en     = 1'b0;
                end else if (!s_q) begin
                    exc_code_d = EXC_PRIVILEGED;
                    icc_en     = 1'b0;
                end else if (wim_q[5'(cwp_inc)]) begin
                    exc_code_d = EXC_UNDERFLOW;
                    icc_en     = 1'b0;
                end else begin
                    et_d  = 1'b1;
                    s_d   = ps_q;
                    cwp_d = cwp_inc;
                end
            end else if (save_req) begin
                if (wim_q[5'(cwp_dec)]) exc_code_d = EXC_OVERFLOW;
                else                    cwp_d      = cwp_dec;
            end else if (restore_req) begin
                if (wim_q[5'(cwp_inc)]) exc_code_d = EXC_UNDERFLOW;
                else                    cwp_d      = cwp_inc;
            end else if (psr_wr) begin
                icc_en = 1'b0;
                if (psr_bad) begin
                    exc_code_d = EXC_ILLEGAL_PSR;
                end else begin
                    icc_d = psr_in[PSR_ICC_LSB +: 4];
                    pil_d = psr_in[PSR_PIL_LSB +: 4];
                    s_d   = psr_in[PSR_S_BIT];
                    ps_d  = psr_in[PSR_PS_BIT];
                    et_d  = psr_in[PSR_ET_BIT];
                    cwp_d = psr_in[CWPW-1:0];
                end
            end else if (wim_wr) begin
                wim_d = wim_in & WIM_MASK;
            end
            if (icc_en) icc_d = icc_in;
        end
        exc_valid_d = (exc_code_d != EXC_NONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            icc_q       <= '0;
            pil_q       <= '0;
            s_q         <= 1'b1;
            ps_q        <= 1'b1;
            et_q        <= 1'b1;
            cwp_q       <= '0;
            wim_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            icc_q       <= icc_d;
            pil_q       <= pil_d;
            s_q         <= s_d;
            ps_q        <= ps_d;
            et_q        <= et_d;
            cwp_q       <= cwp_d;
            wim_q       <= wim_d;
            exc_valid_q <= exc_valid_d;
            exc_code_q  <= exc_code_d;
        end
    end

    always_comb begin
        psr_out                      = '0;
        psr_out[PSR_IMPL_LSB +: 4]   = IMPL;
        psr_out[PSR_VER_LSB +: 4]    = VER;
        psr_out[PSR_ICC_LSB +: 4]    = icc_q;
        psr_out[PSR_PIL_LSB +: 4]    = pil_q;
        psr_out[PSR_S_BIT]           = s_q;
        psr_out[PSR_PS_BIT]          = ps_q;
        psr_out[PSR_ET_BIT]          = et_q;
        psr_out[4:0]                 = 5'(cwp_q);
    end

    assign wim_out    = wim_q;
    assign cwp_out    = cwp_q;
    assign icc_out    = icc_q;
    assign s_out      = s_q;
    assign ps_out     = ps_q;
    assign et_out     = et_q;
    assign exc_valid  = exc_valid_q;
    assign exc_code   = exc_code_q;
    assign error_mode = (state_q == ST_ERROR);

endmodule

// File: tb/tb_psr_wim_unit.sv
// Directed bench: an 8-window unit with nonzero IMPL/VER and a 5-window unit
// for non-power-of-two wrap and WIM masking.
module tb_psr_wim_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-window instance
    logic        a_rst, a_psr_wr, a_wim_wr, a_icc_wr, a_save, a_restore, a_trap, a_rett;
    logic [31:0] a_psr_in, a_wim_in, a_psr_out, a_wim_out;
    logic [3:0]  a_icc_in, a_icc_out;
    logic [2:0]  a_cwp, a_exc_code;
    logic        a_s, a_ps, a_et, a_exc_valid, a_err;

    // 5-window instance
    logic        b_rst, b_psr_wr, b_wim_wr, b_icc_wr, b_save, b_restore, b_trap, b_rett;
    logic [31:0] b_psr_in, b_wim_in, b_psr_out, b_wim_out;
    logic [3:0]  b_icc_in, b_icc_out;
    logic [2:0]  b_cwp, b_exc_code;
    logic        b_s, b_ps, b_et, b_exc_valid, b_err;

    psr_wim_unit #(.NWINDOWS(8), .IMPL(4'hA), .VER(4'h5)) dut_a (
        .clk(clk), .rst(a_rst), .psr_in(a_psr_in), .psr_wr(a_psr_wr),
        .wim_in(a_wim_in), .wim_wr(a_wim_wr), .icc_in(a_icc_in), .icc_wr(a_icc_wr),
        .save_req(a_save), .restore_req(a_restore), .trap_req(a_trap), .rett_req(a_rett),
        .psr_out(a_psr_out), .wim_out(a_wim_out), .cwp_out(a_cwp), .icc_out(a_icc_out),
        .s_out(a_s), .ps_out(a_ps), .et_out(a_et), .exc_valid(a_exc_valid),
        .exc_code(a_exc_code), .error_mode(a_err)
    );

    psr_wim_unit #(.NWINDOWS(5)) dut_b (
        .clk(clk), .rst(b_rst), .psr_in(b_psr_in), .psr_wr(b_psr_wr),
        .wim_in(b_wim_in), .wim_wr(b_wim_wr), .icc_in(b_icc_in), .icc_wr(b_icc_wr),
        .save_req(b_save), .restore_req(b_restore), .trap_req(b_trap), .rett_req(b_rett),
        .psr_out(b_psr_out), .wim_out(b_wim_out), .cwp_out(b_cwp), .icc_out(b_icc_out),
        .s_out(b_s), .ps_out(b_ps), .et_out(b_et), .exc_valid(b_exc_valid),
        .exc_code(b_exc_code), .error_mode(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        a_psr_wr = 0; a_wim_wr = 0; a_icc_wr = 0; a_save = 0;
        a_restore = 0; a_trap = 0; a_rett = 0;
    endtask

    task automatic idle_b();
        b_psr_wr = 0; b_wim_wr = 0; b_icc_wr = 0; b_save = 0;
        b_restore = 0; b_trap = 0; b_rett = 0;
    endtask

    initial begin
        a_rst = 0; b_rst = 0;
        a_psr_in = '0; a_wim_in = '0; a_icc_in = '0;
        b_psr_in = '0; b_wim_in = '0; b_icc_in = '0;
        idle_a(); idle_b();
        a_save = 1; b_restore = 1;   // reset wins over strobes
        tick(); tick();
        idle_a(); idle_b();
        a_rst = 1; b_rst = 1;

        chk("reset_psr",   a_psr_out, 32'hA50000E0);
        chk("reset_wim",   a_wim_out, 32'h0);
        chk("reset_exc",   {a_exc_valid, a_exc_code}, 4'h0);
        chk("reset_err",   a_err, 1'b0);
        chk("reset_psr_b", b_psr_out, 32'h000000E0);

        // save wraps 0 -> 7, restore wraps 7 -> 0
        a_save = 1; tick(); idle_a();
        chk("save_wrap_cwp", a_cwp, 3'd7);
        chk("save_wrap_exc", a_exc_valid, 1'b0);
        chk("save_wrap_psr", a_psr_out, 32'hA50000E7);
        a_restore = 1; tick(); idle_a();
        chk("restore_wrap_cwp", a_cwp, 3'd0);

        // window overflow: CWP=3, WIM[2]=1
        a_psr_wr = 1; a_psr_in = 32'h000000E3; tick(); idle_a();
        chk("wrpsr_cwp3", a_psr_out, 32'hA50000E3);
        a_wim_wr = 1; a_wim_in = 32'h04; tick(); idle_a();
        chk("wim_04", a_wim_out, 32'h04);
        a_save = 1; tick(); idle_a();
        chk("ovf_cwp", a_cwp, 3'd3);
        chk("ovf_exc", {a_exc_valid, a_exc_code}, 4'h9);
        tick();
        chk("ovf_pulse_end", {a_exc_valid, a_exc_code}, 4'h0);

        // window underflow on restore: WIM[4]=1
        a_wim_wr = 1; a_wim_in = 32'h10; tick(); idle_a();
        a_restore = 1; tick(); idle_a();
        chk("unf_cwp", a_cwp, 3'd3);
        chk("unf_exc", {a_exc_valid, a_exc_code}, 4'hA);
        a_wim_wr = 1; a_wim_in = 32'h0; tick(); idle_a();
        a_restore = 1; tick(); idle_a();
        chk("restore_to4", a_cwp, 3'd4);

        // save beats restore; icc_wr rides along
        a_save = 1; a_restore = 1; a_icc_wr = 1; a_icc_in = 4'hA; tick(); idle_a();
        chk("prio_cwp", a_cwp, 3'd3);
        chk("prio_icc", a_icc_out, 4'hA);
        chk("prio_psr", a_psr_out, 32'hA5A000E3);

        // WRPSR: EC/EF/reserved dropped, icc_wr and wim_wr ignored
        a_psr_wr = 1; a_psr_in = 32'hFFFFFF25; a_icc_wr = 1; a_icc_in = 4'h3;
        a_wim_wr = 1; a_wim_in = 32'hFF; tick(); idle_a();
        chk("wrpsr_full", a_psr_out, 32'hA5F00F25);
        chk("wrpsr_wim_ignored", a_wim_out, 32'h0);

        // RETT with ET=1 is illegal
        a_rett = 1; tick(); idle_a();
        chk("rett_et1_exc", {a_exc_valid, a_exc_code}, 4'hB);
        chk("rett_et1_psr", a_psr_out, 32'hA5F00F25);

        // trap entry and return
        a_psr_wr = 1; a_psr_in = 32'h00000022; tick(); idle_a();
        chk("pre_trap", a_psr_out, 32'hA5000022);
        a_trap = 1; a_icc_wr = 1; a_icc_in = 4'h7; tick(); idle_a();
        chk("trap_psr", a_psr_out, 32'hA5000081);
        chk("trap_fields", {a_s, a_ps, a_et, a_cwp}, {3'b100, 3'd1});
        chk("trap_exc", a_exc_valid, 1'b0);
        a_rett = 1; tick(); idle_a();
        chk("rett_psr", a_psr_out, 32'hA5000022);
        chk("rett_fields", {a_s, a_et, a_cwp}, {2'b01, 3'd2});

        // RETT in user mode with traps disabled
        a_psr_wr = 1; a_psr_in = 32'h00000002; tick(); idle_a();
        a_rett = 1; tick(); idle_a();
        chk("rett_priv_exc", {a_exc_valid, a_exc_code}, 4'hC);
        chk("rett_priv_psr", a_psr_out, 32'hA5000002);

        // RETT into an invalid window
        a_psr_wr = 1; a_psr_in = 32'h00000082; tick(); idle_a();
        a_wim_wr = 1; a_wim_in = 32'h08; tick(); idle_a();
        a_rett = 1; tick(); idle_a();
        chk("rett_unf_exc", {a_exc_valid, a_exc_code}, 4'hA);
        chk("rett_unf_psr", a_psr_out, 32'hA5000082);

        // trap with ET=0 enters error mode; everything then frozen
        a_trap = 1; a_psr_wr = 1; a_psr_in = 32'h000000E0; tick(); idle_a();
        chk("err_mode", a_err, 1'b1);
        chk("err_psr", a_psr_out, 32'hA5000082);
        a_save = 1; a_psr_wr = 1; a_psr_in = 32'h000000E1; a_wim_wr = 1;
        a_wim_in = 32'hFF; a_icc_wr = 1; a_icc_in = 4'hF; tick(); tick(); idle_a();
        chk("err_hold_psr", a_psr_out, 32'hA5000082);
        chk("err_hold_wim", a_wim_out, 32'h08);
        chk("err_hold_exc", a_exc_valid, 1'b0);
        chk("err_hold_mode", a_err, 1'b1);
        a_rst = 0; a_save = 1; tick(); idle_a(); a_rst = 1;
        chk("err_reset_psr", a_psr_out, 32'hA50000E0);
        chk("err_reset_mode", a_err, 1'b0);
        chk("err_reset_wim", a_wim_out, 32'h0);

        // 5 windows: wrap, illegal CWP write, WIM masking
        b_save = 1; tick(); idle_b();
        chk("n5_save_wrap", b_cwp, 3'd4);
        b_restore = 1; tick(); idle_b();
        chk("n5_restore_wrap", b_cwp, 3'd0);
        b_psr_wr = 1; b_psr_in = 32'h000000E5; tick(); idle_b();
        chk("n5_badpsr_exc", {b_exc_valid, b_exc_code}, 4'hD);
        chk("n5_badpsr_psr", b_psr_out, 32'h000000E0);
        b_psr_wr = 1; b_psr_in = 32'h000000E4; tick(); idle_b();
        chk("n5_psr_cwp4", b_psr_out, 32'h000000E4);
        b_wim_wr = 1; b_wim_in = 32'hFFFFFFFF; tick(); idle_b();
        chk("n5_wim_mask", b_wim_out, 32'h0000001F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psr_wim_unit.md
PSR_WIM_UNIT -- requirements
Module: psr_wim_unit

Interface
REQ-001 SHALL have parameter NWINDOWS, default 8, number of register windows (legal 2..32).
REQ-002 SHALL have parameters IMPL and VER, default 4'h0 each, constant PSR[31:28] and PSR[27:24] values.
REQ-003 SHALL have derived localparam CWPW = clog2(NWINDOWS), min 1.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-low
- psr_in  in  32  WRPSR data
- psr_wr  in  1  WRPSR strobe
- wim_in  in  32  WRWIM data
- wim_wr  in  1  WRWIM strobe
- icc_in  in  4  condition codes {N,Z,V,C}
- icc_wr  in  1  icc write strobe
- save_req  in  1  SAVE strobe
- restore_req  in  1  RESTORE strobe
- trap_req  in  1  trap-entry strobe
- rett_req  in  1  RETT strobe
- psr_out  out  32  full PSR
- wim_out  out  32  WIM, bits >= NWINDOWS read 0
- cwp_out  out  CWPW  current window pointer
- icc_out  out  4  PSR[23:20]
- s_out, ps_out, et_out  out  1 each  PSR[7], PSR[6], PSR[5]
- exc_valid  out  1  one-cycle exception pulse
- exc_code  out  3  1 overflow, 2 underflow, 3 illegal_instr, 4 privileged, 5 illegal_psr; 0 when exc_valid=0
- error_mode  out  1  processor error state

Function
REQ-005 SHALL accept at most one of trap_req > rett_req > save_req > restore_req > psr_wr > wim_wr per cycle, in this priority; lower strobes that cycle are ignored.
REQ-006 SHALL apply icc_wr in the same cycle as save/restore/wim_wr/rett; icc_wr SHALL be ignored when psr_wr or trap_req is accepted.
REQ-007 SAVE: new = (CWP-1) mod NWINDOWS; if WIM[new]=1, CWP unchanged and exc_code=1; else CWP<=new.
REQ-008 RESTORE: new = (CWP+1) mod NWINDOWS; if WIM[new]=1, CWP unchanged and exc_code=2; else CWP<=new.
REQ-009 Wrap: CWP=0 SAVE SHALL give NWINDOWS-1; CWP=NWINDOWS-1 RESTORE SHALL give 0; non-power-of-two NWINDOWS SHALL wrap the same way.
REQ-010 TRAP with ET=1: PS<=S, S<=1, ET<=0, CWP<=(CWP-1) mod NWINDOWS, no WIM check, no exception.
REQ-011 TRAP with ET=0: state SHALL go RUN->ERROR, error_mode=1 next cycle, PSR unchanged.
REQ-012 RETT: ET=1 -> exc_code=3; else S=0 -> exc_code=4; else WIM[(CWP+1) mod N]=1 -> exc_code=2; else ET<=1, S<=PS, CWP<=(CWP+1) mod N; exception cases change no PSR field.
REQ-013 WRPSR: psr_in[4:0] >= NWINDOWS -> exc_code=5, no write; else PSR[23:0]<=psr_in[23:0] with EC, EF forced 0.
REQ-014 WRWIM SHALL store wim_in with bits >= NWINDOWS cleared.
REQ-015 PSR[31:28]=IMPL, PSR[27:24]=VER, PSR[19:14]=0, PSR[13:12]=0 always; PSR[4:0] = CWP zero-extended.
REQ-016 exc_valid/exc_code SHALL be registered, asserted in the cycle after the offending request, for one cycle.
REQ-017 FSM states RUN, ERROR; ERROR SHALL ignore all strobes and hold every register until reset.
REQ-018 All outputs SHALL be register-driven; no combinational path from any input to any output.

Reset
REQ-019 On clk edge with rst=0: icc=0, PIL=0, S=1, PS=1, ET=1, CWP=0, WIM=0, exc_valid=0, exc_code=0, state RUN, error_mode=0.
REQ-020 Reset SHALL override any simultaneous strobe, including mid-ERROR.

Structure
REQ-021 Shared package SHALL hold exc_code constants, PSR field bit positions and the FSM state enum.
REQ-022 One sub-module psr_cwp_mod SHALL compute (CWP+/-1) mod NWINDOWS; expected RTL 150-300 lines.

Verification
REQ-023 NWINDOWS=8, CWP=0, WIM=0, save_req -> CWP=7, exc_valid=0.
REQ-024 NWINDOWS=8, CWP=3, WIM=8'h04, save_req -> CWP stays 3, exc_valid=1, exc_code=1 one cycle.
REQ-025 ET=1, S=0, CWP=2, trap_req -> S=1, PS=0, ET=0, CWP=1; then rett_req -> ET=1, S=0, CWP=2.
REQ-026 ET=0, trap_req -> error_mode=1; later save_req and psr_wr -> no change; rst=0 -> RUN, ET=1.
REQ-027 NWINDOWS=5, WRPSR psr_in[4:0]=5 -> exc_code=5, PSR unchanged; WRWIM 32'hFFFFFFFF -> wim_out=32'h1F.
REQ-028 save_req+restore_req+icc_wr=4'hA same cycle, CWP=4 -> CWP=3, icc=4'hA.
